// File: rtl/ahb_cfg_pkg.sv
// rtl/ahb_cfg_pkg.sv - shared types, AHB encodings and alignment check for ahb_cfg_arbiter
package ahb_cfg_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Sizes above a word do not exist on this 32-bit slave and are rejected outright.
  function automatic logic align_ok(input logic [2:0] size, input logic [1:0] addr_lsb);
    case (size)
      HSIZE_BYTE: return 1'b1;
      HSIZE_HALF: return ~addr_lsb[0];
      HSIZE_WORD: return (addr_lsb == 2'b00);
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_cfg_arbiter_if.sv
// rtl/ahb_cfg_arbiter_if.sv - requester command ports and AHB-Lite master bus bundle
interface ahb_cfg_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic          req0, req1;
  logic          wr0, wr1;
  logic [2:0]    size0, size1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic          err0, err1;
  logic [DW-1:0] rdata0, rdata1;

  logic          HSEL;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [AW-1:0] HADDR;
  logic [DW-1:0] HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [DW-1:0] HRDATA;
  logic          busy;

  modport master (
    input  req0, req1, wr0, wr1, size0, size1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, err0, err1, rdata0, rdata1,
    output HSEL, HTRANS, HSIZE, HWRITE, HADDR, HWDATA, HREADY, busy,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    output req0, req1, wr0, wr1, size0, size1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
    input  HSEL, HTRANS, HSIZE, HWRITE, HADDR, HWDATA, HREADY, busy,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_cfg_arbiter_rr_arb2.sv
// rtl/ahb_cfg_arbiter_rr_arb2.sv - two-way round-robin arbiter with one-hot grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = last_grant_q ? 2'b01 : 2'b10;
    end
    last_grant_d = last_grant_q;
    if (update_i && (|req_i)) begin
      last_grant_d = grant_o[1];
    end
  end

  // Reset value 1 makes requester 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ahb_cfg_arbiter.sv
// rtl/ahb_cfg_arbiter.sv - two-client round-robin AHB-Lite master for the config register slave
module ahb_cfg_arbiter
  import ahb_cfg_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic               HCLK,
  input  logic               HRESET,
  ahb_cfg_arbiter_if.master  bus
);

  state_t        state_q;
  logic [1:0]    gnt_q;
  logic          wr_q;
  logic [DW-1:0] wdata_q;
  logic          err_acc_q;
  logic          hsel_q, hwrite_q;
  logic [1:0]    htrans_q;
  logic [2:0]    hsize_q;
  logic [AW-1:0] haddr_q;
  logic [DW-1:0] hwdata_q;
  logic [1:0]    ack_q, err_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  logic [1:0]    req, grant;
  logic          sel_wr;
  logic [2:0]    sel_size;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign req = {bus.req1, bus.req0};

  rr_arb2 u_arb (
    .clk      (HCLK),
    .rst      (HRESET),
    .req_i    (req),
    .update_i (state_q == S_IDLE),
    .grant_o  (grant)
  );

  assign sel_wr    = grant[1] ? bus.wr1    : bus.wr0;
  assign sel_size  = grant[1] ? bus.size1  : bus.size0;
  assign sel_addr  = grant[1] ? bus.addr1  : bus.addr0;
  assign sel_wdata = grant[1] ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      gnt_q     <= 2'b00;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      err_acc_q <= 1'b0;
      hsel_q    <= 1'b0;
      htrans_q  <= HTRANS_IDLE;
      hsize_q   <= 3'b000;
      hwrite_q  <= 1'b0;
      haddr_q   <= '0;
      hwdata_q  <= '0;
      ack_q     <= 2'b00;
      err_q     <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            gnt_q   <= grant;
            wr_q    <= sel_wr;
            wdata_q <= sel_wdata;
            if (align_ok(sel_size, sel_addr[1:0])) begin
              state_q  <= S_ADDR;
              hsel_q   <= 1'b1;
              htrans_q <= HTRANS_NONSEQ;
              hsize_q  <= sel_size;
              hwrite_q <= sel_wr;
              haddr_q  <= sel_addr;
            end else begin
              // Rejected commands never touch the bus and complete on the next cycle.
              state_q <= S_RESP;
              ack_q   <= grant;
              err_q   <= grant;
            end
          end
        end
        S_ADDR: begin
          if (bus.HREADYOUT) begin
            state_q  <= S_DATA;
            hsel_q   <= 1'b0;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= wdata_q;
          end
        end
        S_DATA: begin
          if (bus.HRESP) begin
            err_acc_q <= 1'b1;
          end
          if (bus.HREADYOUT) begin
            state_q <= S_RESP;
            ack_q   <= gnt_q;
            err_q   <= gnt_q & {2{err_acc_q | bus.HRESP}};
            if (!wr_q) begin
              if (gnt_q[0]) rdata0_q <= bus.HRDATA;
              if (gnt_q[1]) rdata1_q <= bus.HRDATA;
            end
          end
        end
        S_RESP: begin
          state_q   <= S_IDLE;
          ack_q     <= 2'b00;
          err_q     <= 2'b00;
          err_acc_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.HSEL   = hsel_q;
  assign bus.HTRANS = htrans_q;
  assign bus.HSIZE  = hsize_q;
  assign bus.HWRITE = hwrite_q;
  assign bus.HADDR  = haddr_q;
  assign bus.HWDATA = hwdata_q;
  assign bus.HREADY = bus.HREADYOUT;
  assign bus.ack0   = ack_q[0];
  assign bus.ack1   = ack_q[1];
  assign bus.err0   = err_q[0];
  assign bus.err1   = err_q[1];
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
  assign bus.busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_ahb_cfg_arbiter.sv
// tb/tb_ahb_cfg_arbiter.sv - directed self-checking bench for ahb_cfg_arbiter
module tb_ahb_cfg_arbiter;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb_cfg_arbiter_if #(.AW(4), .DW(32)) bus ();

  ahb_cfg_arbiter #(.AW(4), .DW(32)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus.master)
  );

  // Simple config register slave: four words, byte-lane writes, zero-latency reads.
  logic [31:0] mem [0:3];
  logic        dp_valid;
  logic [3:0]  dp_addr;
  logic [2:0]  dp_size;
  logic        dp_write;

  assign bus.HRDATA = mem[dp_addr[3:2]];

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_addr  <= 4'h0;
      dp_size  <= 3'b000;
      dp_write <= 1'b0;
    end else begin
      if (dp_valid && bus.HREADYOUT) begin
        dp_valid <= 1'b0;
        if (dp_write) begin
          case (dp_size)
            3'b000:  mem[dp_addr[3:2]][8*dp_addr[1:0] +: 8] <= bus.HWDATA[8*dp_addr[1:0] +: 8];
            3'b001:  mem[dp_addr[3:2]][16*dp_addr[1] +: 16] <= bus.HWDATA[16*dp_addr[1] +: 16];
            default: mem[dp_addr[3:2]] <= bus.HWDATA;
          endcase
        end
      end
      if (bus.HSEL && bus.HTRANS == 2'b10 && bus.HREADY) begin
        dp_valid <= 1'b1;
        dp_addr  <= bus.HADDR;
        dp_size  <= bus.HSIZE;
        dp_write <= bus.HWRITE;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_cmd(input int r, input logic wr, input logic [2:0] size,
                         input logic [3:0] addr, input logic [31:0] wdata);
    if (r == 0) begin
      bus.wr0 = wr; bus.size0 = size; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
    end else begin
      bus.wr1 = wr; bus.size1 = size; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
    end
  endtask

  logic        sel_seen;
  logic [1:0]  htrans_c1;
  logic [31:0] hwdata_c2;
  logic        dbl_ack;

  // Runs until an ack appears; cycle n is the n-th edge after the command is presented.
  task automatic run(input int waits, input int resp_cyc, output int who, output int lat,
                     output logic err, output logic [31:0] rd);
    who = -1; lat = 0; err = 1'b0; rd = 32'h0;
    sel_seen = 1'b0; htrans_c1 = 2'b00; hwdata_c2 = 32'h0; dbl_ack = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (bus.HSEL) sel_seen = 1'b1;
      if (n == 1) htrans_c1 = bus.HTRANS;
      if (n == 2) hwdata_c2 = bus.HWDATA;
      if (bus.ack0 || bus.ack1) begin
        who = bus.ack0 ? 0 : 1;
        dbl_ack = bus.ack0 && bus.ack1;
        lat = n;
        err = bus.ack0 ? bus.err0 : bus.err1;
        rd  = bus.ack0 ? bus.rdata0 : bus.rdata1;
        break;
      end
      bus.HREADYOUT = !(n >= 2 && n < 2 + waits);
      bus.HRESP     = (n == resp_cyc);
    end
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 1'b0;
    check("ack_seen", 32'(who >= 0), 32'd1);
    check("single_ack", 32'(dbl_ack), 32'd0);
  endtask

  task automatic drop(input int r);
    if (r == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  int          who, lat;
  logic        err;
  logic [31:0] rd;
  logic        ack_any;

  initial begin
    mem[0] = 32'h0; mem[1] = 32'h0; mem[2] = 32'h1122_3344; mem[3] = 32'h0;
    bus.req0 = 0; bus.req1 = 0; bus.wr0 = 0; bus.wr1 = 0;
    bus.size0 = 0; bus.size1 = 0; bus.addr0 = 0; bus.addr1 = 0;
    bus.wdata0 = 0; bus.wdata1 = 0;
    bus.HREADYOUT = 1'b1; bus.HRESP = 1'b0;

    repeat (3) tick();
    check("rst_hsel",   32'(bus.HSEL), 32'd0);
    check("rst_htrans", 32'(bus.HTRANS), 32'd0);
    check("rst_haddr",  32'(bus.HADDR), 32'd0);
    check("rst_hwdata", bus.HWDATA, 32'd0);
    check("rst_acks",   32'({bus.ack1, bus.ack0, bus.err1, bus.err0}), 32'd0);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_rdata",  bus.rdata0 | bus.rdata1, 32'd0);
    HRESET = 1'b0;
    tick();

    // Tie after reset: requester 0 first, then requester 1 reads back the word.
    set_cmd(0, 1'b1, 3'b010, 4'h4, 32'hA5A5_0001);
    set_cmd(1, 1'b0, 3'b010, 4'h4, 32'h0);
    run(0, -1, who, lat, err, rd);
    check("tie_who",     32'(who), 32'd0);
    check("wr_lat",      32'(lat), 32'd3);
    check("wr_htrans",   32'(htrans_c1), 32'h2);
    check("wr_hwdata",   hwdata_c2, 32'hA5A5_0001);
    check("wr_err",      32'(err), 32'd0);
    drop(0); tick();
    check("wr_mem",      mem[1], 32'hA5A5_0001);
    check("rd1_hold",    bus.rdata1, 32'h0);
    run(0, -1, who, lat, err, rd);
    check("rd_who",      32'(who), 32'd1);
    check("rd_lat",      32'(lat), 32'd3);
    check("rd_data",     rd, 32'hA5A5_0001);
    check("rd_err",      32'(err), 32'd0);
    drop(1); tick();

    set_cmd(0, 1'b1, 3'b000, 4'h9, 32'h3C3C_3C3C);
    run(0, -1, who, lat, err, rd);
    check("byte_who",    32'(who), 32'd0);
    drop(0); tick();
    check("byte_mem",    mem[2], 32'h1122_3C44);

    // Both held: last grant was requester 0, so requester 1 leads the alternation.
    set_cmd(0, 1'b0, 3'b010, 4'h4, 32'h0);
    set_cmd(1, 1'b0, 3'b010, 4'h8, 32'h0);
    for (int i = 0; i < 8; i++) begin
      run(0, -1, who, lat, err, rd);
      check($sformatf("alt_who%0d", i), 32'(who), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    drop(0); drop(1); tick();

    set_cmd(0, 1'b1, 3'b001, 4'h1, 32'hFFFF_FFFF);
    run(0, -1, who, lat, err, rd);
    check("ill_half_lat", 32'(lat), 32'd1);
    check("ill_half_err", 32'(err), 32'd1);
    check("ill_half_sel", 32'(sel_seen), 32'd0);
    drop(0); tick();
    set_cmd(1, 1'b0, 3'b010, 4'h2, 32'h0);
    run(0, -1, who, lat, err, rd);
    check("ill_word_who", 32'(who), 32'd1);
    check("ill_word_lat", 32'(lat), 32'd1);
    check("ill_word_err", 32'(err), 32'd1);
    drop(1); tick();
    set_cmd(0, 1'b1, 3'b011, 4'h0, 32'hFFFF_FFFF);
    run(0, -1, who, lat, err, rd);
    check("ill_size_err", 32'(err), 32'd1);
    check("ill_size_sel", 32'(sel_seen | htrans_c1[1]), 32'd0);
    drop(0); tick();
    check("ill_mem0",     mem[0], 32'h0);

    set_cmd(0, 1'b0, 3'b010, 4'h4, 32'h0);
    run(3, -1, who, lat, err, rd);
    check("wait_lat",    32'(lat), 32'd6);
    check("wait_rdata",  bus.rdata0, 32'hA5A5_0001);
    drop(0); tick();

    set_cmd(1, 1'b1, 3'b010, 4'h0, 32'h0000_DEAD);
    run(1, 2, who, lat, err, rd);
    check("hresp_lat",   32'(lat), 32'd4);
    check("hresp_err",   32'(err), 32'd1);
    drop(1); tick();
    set_cmd(1, 1'b0, 3'b010, 4'h8, 32'h0);
    run(0, -1, who, lat, err, rd);
    check("post_err",    32'(err), 32'd0);
    check("post_rdata",  rd, 32'h1122_3C44);
    drop(1); tick();

    // Reset while the data phase is stalled abandons the transfer.
    set_cmd(0, 1'b1, 3'b010, 4'hC, 32'h5555_5555);
    tick(); tick();
    bus.HREADYOUT = 1'b0;
    tick();
    HRESET = 1'b1;
    #1;
    check("mid_rst_busy",  32'(bus.busy), 32'd0);
    check("mid_rst_bus",   32'({bus.HSEL, bus.HTRANS}), 32'd0);
    check("mid_rst_hwd",   bus.HWDATA, 32'h0);
    bus.req0 = 1'b0;
    bus.HREADYOUT = 1'b1;
    tick();
    HRESET = 1'b0;
    ack_any = 1'b0;
    repeat (5) begin
      tick();
      if (bus.ack0 || bus.ack1) ack_any = 1'b1;
    end
    check("mid_rst_noack", 32'(ack_any), 32'd0);
    check("mid_rst_mem",   mem[3], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
